// File: rtl/alu_seq_if.sv
// Operand/op offer and result return bundle for alu_seq; valid/ready on both sides.
// The master modport is the issuing controller, the slave modport is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry_out;
    logic             zero;
    logic             div_zero;

    modport master (
        output in_valid, a, b, alu_sel, out_ready,
        input  in_ready, out_valid, result, result_hi, carry_out, zero, div_zero
    );

    modport slave (
        input  in_valid, a, b, alu_sel, out_ready,
        output in_ready, out_valid, result, result_hi, carry_out, zero, div_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked 16-op ALU with registered operands/results; 1 cycle latency, WIDTH+1 for MUL/DIV (shift-add / restoring).
// One op in flight: in_ready only in IDLE, result held in DONE until out_ready.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd1;
    localparam logic [2:0] ST_MUL  = 3'd2;
    localparam logic [2:0] ST_DIV  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROTL = 4'b0110;
    localparam logic [3:0] OP_ROTR = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] exec_res, exec_hi;
    logic             exec_carry, exec_dz;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ge;

    // Single-cycle datapath; DIV only reaches EXEC when b==0.
    always_comb begin
        add_full   = {1'b0, opa_q} + {1'b0, opb_q};
        sub_full   = {1'b0, opa_q} - {1'b0, opb_q};
        exec_res   = '0;
        exec_hi    = '0;
        exec_carry = 1'b0;
        exec_dz    = 1'b0;
        case (op_q)
            OP_ADD:  begin exec_res = add_full[WIDTH-1:0]; exec_carry = add_full[WIDTH]; end
            OP_SUB:  begin exec_res = sub_full[WIDTH-1:0]; exec_carry = sub_full[WIDTH]; end
            OP_DIV:  begin exec_res = '1; exec_hi = opa_q; exec_dz = 1'b1; end
            OP_SHL:  exec_res = {opa_q[WIDTH-2:0], 1'b0};
            OP_SHR:  exec_res = {1'b0, opa_q[WIDTH-1:1]};
            OP_ROTL: exec_res = {opa_q[WIDTH-2:0], opa_q[WIDTH-1]};
            OP_ROTR: exec_res = {opa_q[0], opa_q[WIDTH-1:1]};
            OP_AND:  exec_res = opa_q & opb_q;
            OP_OR:   exec_res = opa_q | opb_q;
            OP_XOR:  exec_res = opa_q ^ opb_q;
            OP_NOR:  exec_res = ~(opa_q | opb_q);
            OP_NAND: exec_res = ~(opa_q & opb_q);
            OP_XNOR: exec_res = ~(opa_q ^ opb_q);
            OP_GT:   exec_res = {{(WIDTH-1){1'b0}}, (opa_q > opb_q)};
            OP_EQ:   exec_res = {{(WIDTH-1){1'b0}}, (opa_q == opb_q)};
            default: ;
        endcase
    end

    // Iteration steps. MUL keeps {acc_hi, acc_lo} as partial product / multiplier;
    // DIV keeps acc_hi as remainder and shifts quotient bits into acc_lo.
    // The remainder stays below b, so the top bit of div_diff is the restore flag.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        div_ge   = ~div_diff[WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        op_d        = op_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        div_zero_d  = div_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    opa_d    = bus.a;
                    opb_d    = bus.b;
                    op_d     = bus.alu_sel;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    acc_lo_d = bus.a;
                    if (bus.alu_sel == OP_MUL)
                        state_d = ST_MUL;
                    else if (bus.alu_sel == OP_DIV && bus.b != '0)
                        state_d = ST_DIV;
                    else
                        state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d    = exec_res;
                result_hi_d = exec_hi;
                carry_d     = exec_carry;
                zero_d      = (exec_res == '0);
                div_zero_d  = exec_dz;
                state_d     = ST_DONE;
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    result_d    = acc_lo_q;
                    result_hi_d = acc_hi_q;
                    carry_d     = 1'b0;
                    zero_d      = (acc_lo_q == '0);
                    div_zero_d  = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == ST_MUL) begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end else begin
                        acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            op_q        <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            op_q        <= op_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.div_zero  = div_zero_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Same 16-op encoding. Operands and results are registered.
- MUL and DIV are iterative (one bit per cycle). Carry, zero and divide-by-zero flags are added.
- Sits between an operand-issuing controller FSM and a result consumer; valid/ready on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4)
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op offer
- in_ready  out  1  block can accept (high only in IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- alu_sel  in  4  opcode
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  primary result (low product / quotient)
- result_hi  out  WIDTH  high product / remainder; 0 for other ops
- carry_out  out  1  ADD carry; SUB borrow (1 when a<b); 0 otherwise
- zero  out  1  result==0
- div_zero  out  1  DIV with b==0

Behaviour:
- Interface: one clock; reset is synchronous and active-high (rst sampled on rising clk).
- Reset (also mid-operation):
  - state=IDLE, in_ready=1, out_valid=0.
  - result, result_hi, carry_out, zero, div_zero all 0.
  - Counter and internal operand registers cleared; in-flight op discarded.
- Accept: when in_valid&&in_ready, latch a, b, alu_sel. Inputs are ignored at all other times.
- States:
  - IDLE: on accept, go to MUL if op=0010; DIV if op=0011 and b!=0; otherwise EXEC.
  - EXEC: compute single-cycle op → DONE (result valid 1 cycle after accept).
  - MUL: shift-add, WIDTH iterations → DONE (out_valid asserted WIDTH+1 cycles after accept).
  - DIV: restoring division, WIDTH iterations → DONE (latency WIDTH+1).
  - DONE: out_valid=1. Outputs are held stable until out_ready; on out_valid&&out_ready go to IDLE. No result overlap; max throughput is one op per latency+2 cycles.
- Opcodes (all arithmetic modulo 2^WIDTH unless stated):
  - 0000 add; 0001 sub; 0010 mul (full 2·WIDTH product split result_hi:result, unsigned); 0011 div (unsigned quotient/remainder).
  - 0100 shl1; 0101 shr1 (logical, zero fill); 0110 rotl1; 0111 rotr1.
  - 1000 and; 1001 or; 1010 xor; 1011 nor; 1100 nand; 1101 xnor.
  - 1110 result = (a>b) ? 1 : 0; 1111 result = (a==b) ? 1 : 0 (unsigned).
- Divide by zero: handled in EXEC (latency 1). result=all ones, result_hi=a, div_zero=1.
- Flags: zero tracks result only (not result_hi). carry_out is computed as a WIDTH+1-bit sum/difference. div_zero=0 except as above.
- Flags and result update together on entry to DONE and never change while out_valid=1.
- Out-of-range/default: none (4-bit opcode is fully decoded).

Test Plan:
- WIDTH=8, a=0x0A, b=0x02, sweep alu_sel 0..15 with out_ready=1 → results:
  - 0C, 08, 14 (hi 00), 05 (hi 00), 14, 05, 14, 05
  - 02, 0A, 08, F5, FD, F7, 01, 00
  - 1-cycle latency except mul/div (9 cycles)
- a=0xF6, b=0x0A, add → result 0x00, carry_out=1, zero=1; sub → 0xEC, carry_out=0.
- a=0xF6, b=0x0A, mul → result 0x9C, result_hi 0x09 at cycle 9 after accept. div → result 0x18, result_hi 0x06. Check in_ready=0 throughout.
- a=0x37, b=0x00, div → out_valid next cycle, result 0xFF, result_hi 0x37, div_zero=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, new in_valid ignored; then out_ready=1 → IDLE next cycle.
- Assert rst at iteration 4 of mul → next cycle IDLE, all outputs 0. A following add 0x01+0x01 → 0x02 with no stale state.
